// File: rtl/led_pattern_seq.sv
// Button-stepped, run-time writable circular LED pattern sequencer.
// Define LEDSEQ_DEBOUNCE_EN to insert a debouncer after each button synchroniser.

module led_btn_edge #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic step_o
);
    logic s1_q, s2_q, edge_q;
    logic deb;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("led_btn_edge: DEB_CYCLES must be >= 1");
    end

`ifdef LEDSEQ_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    logic [CW-1:0] cnt_q;
    logic          deb_q;

    // Accept a new level only after it has differed from deb for DEB_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else if (s2_q == deb_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_q <= s2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign deb = deb_q;
`else
    assign deb = s2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            edge_q <= deb;
        end
    end

    assign step_o = deb & ~edge_q;
endmodule

module led_pattern_seq #(
    parameter int LED_W      = 3,
    parameter int NUM_STATES = 4,
    parameter int DEB_CYCLES = 4,
    parameter int AUTO_DIV   = 8,
    localparam int SW        = $clog2(NUM_STATES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btnD,
    input  logic             btnU,
    input  logic             mode_auto,
    input  logic             pat_we,
    input  logic [3:0]       pat_addr,
    input  logic [LED_W-1:0] pat_data,
    output logic [LED_W-1:0] ledOut,
    output logic [SW-1:0]    state_idx,
    output logic             wrap
);
    localparam int TW = $clog2(AUTO_DIV);
    localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);

    if (AUTO_DIV < 2 || NUM_STATES < 2 || NUM_STATES > 16 ||
        LED_W < 1 || LED_W > 16) begin : g_bad_cfg
        $error("led_pattern_seq: parameter out of range");
    end

    logic             step_f, step_b;
    logic [SW-1:0]    idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [LED_W-1:0] tbl_q [NUM_STATES];
    logic             idx_ok, auto_tick, mv_f, mv_b, wr_ok;

    led_btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_btn_d (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btnD),
        .step_o(step_f)
    );

    led_btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_btn_u (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btnU),
        .step_o(step_b)
    );

    assign idx_ok    = 32'(idx_q) < NUM_STATES;
    assign auto_tick = mode_auto && (tmr_q == TW'(AUTO_DIV - 1));
    // Simultaneous steps cancel; a button step always beats the auto tick
    assign mv_f = idx_ok && ((step_f && !step_b) || (!step_f && !step_b && auto_tick));
    assign mv_b = idx_ok && step_b && !step_f;
    assign wr_ok = pat_we && ({1'b0, pat_addr} < 5'(NUM_STATES));

    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (!mode_auto || step_f || step_b || auto_tick) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
        unique case (1'b1)
            !idx_ok: idx_d = '0;
            mv_f: begin
                if (idx_q == LAST) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            mv_b: begin
                if (idx_q == '0) begin
                    idx_d  = LAST;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
            tmr_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            tmr_q  <= tmr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                tbl_q[i] <= LED_W'(i + 1);
            end
        end else if (wr_ok) begin
            tbl_q[pat_addr[SW-1:0]] <= pat_data;
        end
    end

    assign ledOut    = idx_ok ? tbl_q[idx_q] : '0;
    assign state_idx = idx_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: stimulus queues expected outputs per
// clock edge, a negedge monitor pops and compares them.

module tb_led_pattern_seq;
`ifdef LEDSEQ_DEBOUNCE_EN
    localparam int LAT    = 7;
    localparam int GL_IDX = 2;
    localparam int GL_LED = 3;
`else
    localparam int LAT    = 3;
    localparam int GL_IDX = 3;
    localparam int GL_LED = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnD = 1'b0;
    logic       btnU = 1'b0;
    logic       mode_auto = 1'b0;
    logic       pat_we = 1'b0;
    logic [3:0] pat_addr = '0;
    logic [2:0] pat_data = '0;
    logic [2:0] ledOut;
    logic [1:0] state_idx;
    logic       wrap;

    typedef struct {
        int    cyc;
        int    idx;
        int    led;
        int    wr;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   e0;

    led_pattern_seq dut (
        .clk      (clk),
        .rst      (rst),
        .btnD     (btnD),
        .btnU     (btnU),
        .mode_auto(mode_auto),
        .pat_we   (pat_we),
        .pat_addr (pat_addr),
        .pat_data (pat_data),
        .ledOut   (ledOut),
        .state_idx(state_idx),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (it.cyc != cyc || int'(state_idx) != it.idx ||
                int'(ledOut) != it.led || int'(wrap) != it.wr) begin
                errors++;
                $display("FAIL %s edge %0d (now %0d): idx %0d led %b wrap %b, want idx %0d led %b wrap %0d",
                         it.nm, it.cyc, cyc, state_idx, ledOut, wrap,
                         it.idx, it.led[2:0], it.wr);
            end
        end
    end

    task automatic expect_at(input int c, input int idx, input int led,
                             input int wr, input string nm);
        exp_t e;
        e.cyc = c;
        e.idx = idx;
        e.led = led;
        e.wr  = wr;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit f, input bit b, input int idx,
                         input int led, input int wr, input string nm);
        int s;
        s = cyc;
        btnD = f;
        btnU = b;
        expect_at(s + LAT, idx, led, wr, nm);
        expect_at(s + LAT + 1, idx, led, 0, {nm, "_next"});
        tick(8);
        btnD = 1'b0;
        btnU = 1'b0;
        tick(14);
    endtask

    // Reset asserted mid-cycle must clear outputs before the next edge
    task automatic rst_mid(input string nm);
        #3;
        rst = 1'b1;
        expect_at(cyc, 0, 1, 0, nm);
        tick(1);
    endtask

    initial begin
        tick(2);
        expect_at(cyc, 0, 1, 0, "rst_init");
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            expect_at(cyc + k, 0, 1, 0, "idle_hold");
        end
        tick(52);

        e0 = cyc;
        btnD = 1'b1;
        expect_at(e0 + LAT - 1, 0, 1, 0, "hold_pre");
        expect_at(e0 + LAT, 1, 2, 0, "hold_step");
        expect_at(e0 + LAT + 1, 1, 2, 0, "hold_once");
        expect_at(e0 + 19, 1, 2, 0, "hold_end");
        tick(20);
        btnD = 1'b0;
        tick(14);

        press(1, 0, 2, 3, 0, "fwd2");
        press(1, 0, 3, 4, 0, "fwd3");
        press(1, 0, 0, 1, 1, "fwd_wrap");
        press(0, 1, 3, 4, 1, "bwd_wrap");
        press(0, 1, 2, 3, 0, "bwd2");

        e0 = cyc;
        btnD = 1'b1;
        expect_at(e0 + 10, GL_IDX, GL_LED, 0, "glitch");
        tick(3);
        btnD = 1'b0;
        tick(15);

        e0 = cyc;
        btnD = 1'b1;
        btnU = 1'b1;
        expect_at(e0 + LAT, GL_IDX, GL_LED, 0, "both");
        expect_at(e0 + LAT + 5, GL_IDX, GL_LED, 0, "both_late");
        tick(8);
        btnD = 1'b0;
        btnU = 1'b0;
        tick(14);

        rst_mid("rst_mid1");
        rst = 1'b0;
        tick(2);

        e0 = cyc;
        pat_we = 1'b1;
        pat_addr = 4'd0;
        pat_data = 3'b111;
        expect_at(e0, 0, 1, 0, "wr_pre");
        expect_at(e0 + 1, 0, 7, 0, "wr_cur");
        tick(1);
        pat_addr = 4'd5;
        pat_data = 3'b000;
        expect_at(e0 + 2, 0, 7, 0, "wr_oob");
        tick(1);
        pat_addr = 4'd2;
        pat_data = 3'b110;
        tick(1);
        pat_we = 1'b0;
        press(1, 0, 1, 2, 0, "oob_kept");
        press(1, 0, 2, 6, 0, "wr_other");

        e0 = cyc;
        btnD = 1'b1;
        expect_at(e0 + LAT, 3, 5, 0, "wr_and_step");
        tick(LAT - 1);
        pat_we = 1'b1;
        pat_addr = 4'd3;
        pat_data = 3'b101;
        tick(1);
        pat_we = 1'b0;
        tick(10 - LAT);
        btnD = 1'b0;
        tick(14);

        rst_mid("rst_table");
        rst = 1'b0;
        tick(2);
        press(0, 1, 3, 4, 1, "tbl_restored");

        rst_mid("rst_auto");
        rst = 1'b0;
        mode_auto = 1'b1;
        e0 = cyc;
        expect_at(e0 + 7, 0, 1, 0, "auto_pre");
        expect_at(e0 + 8, 1, 2, 0, "auto1");
        expect_at(e0 + 16, 2, 3, 0, "auto2");
        expect_at(e0 + 24, 3, 4, 0, "auto3");
        expect_at(e0 + 31, 3, 4, 0, "auto_prewrap");
        expect_at(e0 + 32, 0, 1, 1, "auto_wrap");
        expect_at(e0 + 33, 0, 1, 0, "auto_wrap_clr");
        expect_at(e0 + 40, 1, 2, 0, "auto5");
        expect_at(e0 + 44, 0, 1, 0, "auto_btn_bwd");
        expect_at(e0 + 48, 0, 1, 0, "auto_restart");
        expect_at(e0 + 51, 0, 1, 0, "auto_pre_next");
        expect_at(e0 + 52, 1, 2, 0, "auto_next");
        tick(44 - LAT);
        btnU = 1'b1;
        tick(8);
        btnU = 1'b0;
        tick(4 + LAT);
        mode_auto = 1'b0;

        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            tick(1);
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
